dac_tx: RTL
===========

Name: dac_tx

Overview:
- Transmit-side counterpart of the ADC capture path: accepts 10-bit samples from the processing chain over a valid/ready handshake and buffers them in a small FIFO.
- Drives a parallel 10-bit DAC at a fixed fraction of `clk`, generating the DAC update clock.
- Used to play filtered or reconstructed waveforms back out of the FPGA.
- Priming, underrun detection and an idle midscale output keep the analog output well-defined at all times.

Parameters:
- DATA_W, 10: sample width, matches the DAC.
- DIV, 4: `clk` cycles per DAC sample. Even, >= 2.
- DEPTH, 16: FIFO depth. Power of two, >= 4.
- PRIME_LVL, 4: FIFO level required before playback starts. 1 <= PRIME_LVL <= DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  playback enable.
- in_data  input  DATA_W  sample from upstream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready.
- clr_underrun  input  1  clears the sticky underrun flag.
- dac_data  output  DATA_W  registered DAC data bus, offset binary.
- dac_clk  output  1  DAC latch clock; the DAC samples on its rising edge.
- underrun  output  1  sticky underrun flag.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous on rst high):
  - dac_data = 10'h200 (midscale).
  - dac_clk = 0.
  - underrun = 0.
  - fifo_level = 0.
  - in_ready = 1.
  - Divider count cnt = 0; state = IDLE; FIFO pointers = 0.
- FIFO:
  - in_ready = (level != DEPTH); a combinational function of registered level.
  - Push on in_valid && in_ready. in_data is ignored when in_ready = 0.
  - A pop occurs only on a tick in RUN with level != 0.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Divider:
  - cnt counts 0..DIV-1 continuously, in all states.
  - tick = (cnt == DIV-1).
  - dac_clk is registered: it is 1 when the next cnt >= DIV/2, else 0.
  - Result: dac_data changes when cnt returns to 0 (dac_clk low) and dac_clk rises DIV/2 cycles later, so data is stable around the DAC latch edge.
- FSM:
  - IDLE: dac_data held at 10'h200. Goes to PRIME when enable = 1.
  - PRIME: dac_data held at 10'h200. Goes to RUN on a tick where level >= PRIME_LVL. No pop on that tick; first pop is on the next tick.
  - RUN, on each tick:
    - If level != 0: pop, and dac_data <= head sample (through the optional conversion).
    - If level == 0: dac_data holds its last value, underrun <= 1, and the state stays RUN (no re-prime).
  - Any state: enable = 0 goes to IDLE in the next cycle and dac_data <= 10'h200 in the same update. FIFO contents are retained and input is still accepted.
- Latency: the first sample reaches dac_data on the first tick after PRIME exits, at most 2*DIV cycles after the PRIME_LVL-th push.
- underrun:
  - Set in the cycle after an empty tick in RUN.
  - clr_underrun clears it in the next cycle.
  - If set and clear coincide, set wins.
- fifo_level is a registered count. It equals DEPTH when full and 0 when empty.
- rst asserted mid-playback: immediate return to reset values, and the FIFO is emptied.

Optional Feature:
- Macro: DAC_TX_TWOS_COMP_EN.
- Defined: in_data is two's complement. The MSB is inverted on pop before loading dac_data, so 10'h000 drives 10'h200 and 10'h3FF drives 10'h1FF.
- Undefined: in_data is offset binary and is passed unchanged.
- Idle and reset midscale is 10'h200 in both builds.

Test Plan (DIV=4, DEPTH=16, PRIME_LVL=4, macro undefined unless stated):
1. Reset, then enable=1 and push 10'h001..10'h004 back-to-back -> PRIME exits; dac_data goes 10'h200 -> 001 -> 002 -> 003 -> 004, one step every 4 cycles, each change with dac_clk=0 and dac_clk rising 2 cycles later; then underrun=1 and dac_data holds 004.
2. enable=0, push 20 samples with in_valid held high -> in_ready falls after the 16th push, fifo_level=16, pushes 17-20 rejected; enable=1 -> playback of the first 16 values only.
3. Continuous push at the drain rate in RUN, with push and pop in the same cycle -> fifo_level constant, no underrun, output sequence matches the input sequence.
4. Deassert enable mid-RUN with 5 samples queued -> dac_data=10'h200 the next cycle, fifo_level stays 5; re-enable -> queued samples resume in order.
5. underrun set, then clr_underrun pulsed on the same cycle as a new empty tick -> underrun remains 1; pulsed alone -> underrun=0 in the next cycle.
6. Macro defined, push 10'h000 and 10'h3FF -> dac_data 10'h200 then 10'h1FF; assert rst mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dac_tx.sv
// dac_tx: FIFO-buffered sample playback to a parallel DAC with a generated latch clock.
// Build macro DAC_TX_TWOS_COMP_EN: in_data is two's complement (MSB flipped on pop).
module dac_tx #(
  parameter int DATA_W    = 10,
  parameter int DIV       = 4,
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clr_underrun,
  output logic [DATA_W-1:0]      dac_data,
  output logic                   dac_clk,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(DIV / 2);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_PRIME = LVL_W'(PRIME_LVL);
  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                tick_s;
  logic                dac_clk_r;
  logic [DATA_W-1:0]   dac_data_r;
  logic [DATA_W-1:0]   dac_data_nxt_s;
  logic                underrun_r;
  logic                underrun_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [LVL_W-1:0]    level_r;
  logic                push_s;
  logic                pop_s;
  logic                run_tick_s;
  logic                empty_tick_s;

  // Sample format conversion applied on the way from FIFO head to the DAC bus.
  function automatic logic [DATA_W-1:0] conv_sample(input logic [DATA_W-1:0] s);
`ifdef DAC_TX_TWOS_COMP_EN
    conv_sample = {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    conv_sample = s;
`endif
  endfunction

  assign tick_s       = (cnt_r == CNT_LAST);
  assign cnt_nxt_s    = tick_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
  assign in_ready     = (level_r != LVL_FULL);
  assign push_s       = in_valid && in_ready;
  // Disabling takes priority over a coincident tick, so nothing is consumed while leaving RUN.
  assign run_tick_s   = tick_s && enable && (state_r == S_RUN);
  assign pop_s        = run_tick_s && (level_r != {LVL_W{1'b0}});
  assign empty_tick_s = run_tick_s && (level_r == {LVL_W{1'b0}});

  assign dac_data   = dac_data_r;
  assign dac_clk    = dac_clk_r;
  assign underrun   = underrun_r;
  assign fifo_level = level_r;

  // Free-running divider; dac_clk is high for the second half of each sample period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      dac_clk_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      dac_clk_r <= (cnt_nxt_s >= CNT_HALF);
    end
  end

  // FIFO storage write port; stale entries are harmless because pointers define contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_nxt_s = S_PRIME;
        S_PRIME: begin
          if (tick_s && (level_r >= LVL_PRIME)) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_PRIME;
          end
        end
        S_RUN:   state_nxt_s = S_RUN;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // FSM outputs: next DAC word and sticky underrun (set beats clear).
  always_comb begin
    dac_data_nxt_s = dac_data_r;
    underrun_nxt_s = underrun_r;
    if (!enable || (state_r != S_RUN)) begin
      dac_data_nxt_s = MIDSCALE;
    end else if (pop_s) begin
      dac_data_nxt_s = conv_sample(mem_r[rd_ptr_r]);
    end else begin
      dac_data_nxt_s = dac_data_r;
    end
    if (empty_tick_s) begin
      underrun_nxt_s = 1'b1;
    end else if (clr_underrun) begin
      underrun_nxt_s = 1'b0;
    end else begin
      underrun_nxt_s = underrun_r;
    end
  end

  // Registered DAC bus and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data_r <= MIDSCALE;
      underrun_r <= 1'b0;
    end else begin
      dac_data_r <= dac_data_nxt_s;
      underrun_r <= underrun_nxt_s;
    end
  end

endmodule
